// File: rtl/uart_dbg_loader.sv
// -----------------------------------------------------------------------------
// uart_dbg_loader
//
// Debug command engine sitting between a UART byte receiver/transmitter and
// the SoC debug memory port. The host sends byte packets:
//   'W' (0x57) a0 a1 a2 a3 d0 d1 d2 d3  write 32-bit word, LSB first, ACK
//   'R' (0x52) a0 a1 a2 a3              read 32-bit word, 4 data bytes back
//   'H' (0x48)                          hold CPU in reset, ACK
//   'G' (0x47)                          release CPU reset, ACK
//   anything else                       NAK
// Memory commands are only honoured while the CPU is halted; otherwise the
// whole packet is consumed and answered with NAK without touching the bus.
// A packet whose bytes are spaced by TIMEOUT idle cycles is dropped silently.
//
// Handshakes:
//   rx side : rx_valid is a one-cycle strobe with no back-pressure; bytes
//             arriving while a bus access or response is in progress are lost.
//   tx side : valid/ready. tx_valid and tx_data are held stable until the
//             cycle in which tx_valid && tx_ready, which transfers one byte.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rx_data, rx_valid   received byte and its strobe
//   tx_data, tx_valid   byte to transmit and its request
//   tx_ready            transmitter accepts the byte
//   dbg_mem_op          debug bus owns memory (held MEM_WAIT cycles)
//   dbg_adr, dbg_do     access address and write data
//   dbg_wren            byte enables, 4'hF write / 4'h0 read
//   dbg_di              read data, sampled on the last held cycle
//   cpu_n_reset         CPU reset, active low
//   state_o             current FSM state (IDLE=0 ADDR=1 DATA=2 MEM=3 RESP=4)
// -----------------------------------------------------------------------------
module uart_dbg_loader #(
  parameter int unsigned MEM_WAIT    = 4,
  parameter int unsigned TIMEOUT     = 100000,
  parameter bit          BOOT_HALTED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dbg_mem_op,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  output logic [3:0]  dbg_wren,
  input  logic [31:0] dbg_di,
  output logic        cpu_n_reset,
  output logic [2:0]  state_o
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  // Idle counter only needs to reach TIMEOUT-1; the following idle cycle aborts.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MEM_LAST = 8'(MEM_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_MEM  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t         state_q,     state_d;
  logic           is_write_q,  is_write_d;
  logic [1:0]     byte_cnt_q,  byte_cnt_d;
  logic [TW-1:0]  tmo_q,       tmo_d;
  logic [31:0]    adr_sh_q,    adr_sh_d;
  logic [31:0]    dat_sh_q,    dat_sh_d;
  logic [7:0]     wait_q,      wait_d;
  logic           mem_op_q,    mem_op_d;
  logic [3:0]     wren_q,      wren_d;
  logic [31:0]    bus_adr_q,   bus_adr_d;
  logic [31:0]    bus_do_q,    bus_do_d;
  logic [7:0]     tx_data_q,   tx_data_d;
  logic           tx_valid_q,  tx_valid_d;
  logic [23:0]    resp_buf_q,  resp_buf_d;
  logic [1:0]     resp_left_q, resp_left_d;
  logic           cpu_nrst_q,  cpu_nrst_d;

  // Address/data bytes arrive LSB first: shifting in from the top leaves
  // byte i in bits 8i+7:8i once all four have been seen.
  logic [31:0] adr_next;
  logic [31:0] dat_next;
  assign adr_next = {rx_data, adr_sh_q[31:8]};
  assign dat_next = {rx_data, dat_sh_q[31:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= 2'd0;
      tmo_q       <= '0;
      adr_sh_q    <= 32'h0;
      dat_sh_q    <= 32'h0;
      wait_q      <= 8'h0;
      mem_op_q    <= 1'b0;
      wren_q      <= 4'h0;
      bus_adr_q   <= 32'h0;
      bus_do_q    <= 32'h0;
      tx_data_q   <= 8'h0;
      tx_valid_q  <= 1'b0;
      resp_buf_q  <= 24'h0;
      resp_left_q <= 2'd0;
      cpu_nrst_q  <= ~BOOT_HALTED;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      adr_sh_q    <= adr_sh_d;
      dat_sh_q    <= dat_sh_d;
      wait_q      <= wait_d;
      mem_op_q    <= mem_op_d;
      wren_q      <= wren_d;
      bus_adr_q   <= bus_adr_d;
      bus_do_q    <= bus_do_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      resp_buf_q  <= resp_buf_d;
      resp_left_q <= resp_left_d;
      cpu_nrst_q  <= cpu_nrst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    adr_sh_d    = adr_sh_q;
    dat_sh_d    = dat_sh_q;
    wait_d      = wait_q;
    mem_op_d    = mem_op_q;
    wren_d      = wren_q;
    bus_adr_d   = bus_adr_q;
    bus_do_d    = bus_do_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    resp_buf_d  = resp_buf_q;
    resp_left_d = resp_left_q;
    cpu_nrst_d  = cpu_nrst_q;

    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (rx_valid) begin
          byte_cnt_d  = 2'd0;
          resp_left_d = 2'd0;
          unique case (rx_data)
            CMD_W: begin
              is_write_d = 1'b1;
              state_d    = S_ADDR;
            end
            CMD_R: begin
              is_write_d = 1'b0;
              state_d    = S_ADDR;
            end
            CMD_H: begin
              cpu_nrst_d = 1'b0;
              tx_data_d  = ACK;
              tx_valid_d = 1'b1;
              state_d    = S_RESP;
            end
            CMD_G: begin
              cpu_nrst_d = 1'b1;
              tx_data_d  = ACK;
              tx_valid_d = 1'b1;
              state_d    = S_RESP;
            end
            default: begin
              tx_data_d  = NAK;
              tx_valid_d = 1'b1;
              state_d    = S_RESP;
            end
          endcase
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          tmo_d      = '0;
          adr_sh_d   = adr_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (is_write_q) begin
              state_d = S_DATA;
            end else if (cpu_nrst_q) begin
              // CPU running: memory is not ours to touch.
              tx_data_d  = NAK;
              tx_valid_d = 1'b1;
              state_d    = S_RESP;
            end else begin
              bus_adr_d = adr_next;
              wren_d    = 4'h0;
              mem_op_d  = 1'b1;
              wait_d    = 8'h0;
              state_d   = S_MEM;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          tmo_d      = '0;
          dat_sh_d   = dat_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (cpu_nrst_q) begin
              tx_data_d  = NAK;
              tx_valid_d = 1'b1;
              state_d    = S_RESP;
            end else begin
              bus_adr_d = adr_sh_q;
              bus_do_d  = dat_next;
              wren_d    = 4'hF;
              mem_op_d  = 1'b1;
              wait_d    = 8'h0;
              state_d   = S_MEM;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_MEM: begin
        // Address, data and enables stay frozen for the whole access; the
        // last held cycle is also the one where read data is valid.
        if (wait_q == MEM_LAST) begin
          mem_op_d   = 1'b0;
          wren_d     = 4'h0;
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
          if (is_write_q) begin
            tx_data_d   = ACK;
            resp_left_d = 2'd0;
          end else begin
            tx_data_d   = dbg_di[7:0];
            resp_buf_d  = dbg_di[31:8];
            resp_left_d = 2'd3;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_RESP: begin
        if (tx_valid_q && tx_ready) begin
          if (resp_left_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d   = resp_buf_q[7:0];
            resp_buf_d  = {8'h0, resp_buf_q[23:8]};
            resp_left_d = resp_left_q - 2'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign dbg_mem_op  = mem_op_q;
  assign dbg_adr     = bus_adr_q;
  assign dbg_do      = bus_do_q;
  assign dbg_wren    = wren_q;
  assign cpu_n_reset = cpu_nrst_q;
  assign state_o     = state_q;

endmodule
